dac_stream_tx: RTL and testbench

- Transmit-side streaming driver for the 8-bit DAC half of the AD/DA add-on board.
- Accepts samples on a valid/ready stream into a small FIFO and paces them onto the DAC data pins at a programmable sample rate.
- Generates the DACLK strobe.
- Sits between any sample producer (NCO, ADC capture path, host buffer) and the DA_PORT pins at top level.

---
 rtl/dac_stream_tx.sv | 124 ++++++++++++
 tb/tb_dac_stream_tx.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_stream_tx.sv
// Streaming DAC driver: valid/ready sample FIFO paced onto the DAC pins with a DACLK strobe.
// Optional `DAC_SIGNED_IN_EN: two's-complement input converted to offset binary (mid-scale reset).
module dac_stream_tx #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 8,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic [DIV_W-1:0]              i_div,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [DATA_W-1:0]             o_da_port,
  output logic                          o_daclk,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_underrun,
  input  logic                          i_clr_underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0]      PRIME_LVL = (AW+1)'(PRIME_LEVEL);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
`ifdef DAC_SIGNED_IN_EN
  localparam logic [DATA_W-1:0] DA_RST = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DA_XOR = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] DA_RST = '0;
  localparam logic [DATA_W-1:0] DA_XOR = '0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic                ready_en_q;
  logic [DIV_W-1:0]    cnt_q, per_q, per_d, half;
  logic [DIV_W:0]      per_p1;
  logic [DATA_W-1:0]   da_q;
  logic                daclk_q, underrun_q;
  logic                full, empty, push, pop, tick;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign o_level = wr_ptr_q - rd_ptr_q;
  assign o_ready = ready_en_q && !full;
  assign push    = i_valid && o_ready;
  assign tick    = (state_q == ST_RUN) && i_enable && (cnt_q == '0);
  assign pop     = tick && !empty;

  // per_q holds P-1 for the current period; the rising strobe lands at floor(P/2).
  assign per_d  = (i_div == '0) ? DIV_ONE : i_div;
  assign per_p1 = {1'b0, per_q} + (DIV_W+1)'(1);
  assign half   = per_p1[DIV_W:1];

  assign o_da_port  = da_q;
  assign o_daclk    = daclk_q;
  assign o_underrun = underrun_q;

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ready_en_q <= 1'b0;
      cnt_q      <= '0;
      per_q      <= DIV_ONE;
      da_q       <= DA_RST;
      daclk_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;

      if (tick && empty)       underrun_q <= 1'b1;
      else if (i_clr_underrun) underrun_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          cnt_q   <= '0;
          daclk_q <= 1'b0;
          if (i_enable) state_q <= ST_PRIME;
        end
        ST_PRIME: begin
          cnt_q   <= '0;
          daclk_q <= 1'b0;
          if (!i_enable)                state_q <= ST_IDLE;
          else if (o_level >= PRIME_LVL) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!i_enable) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            daclk_q <= 1'b0;
          end else if (cnt_q == '0) begin
            // Tick branch first: a stale per_q can never wrap or strobe here.
            per_q   <= per_d;
            cnt_q   <= DIV_ONE;
            daclk_q <= 1'b0;
            if (!empty) da_q <= mem_q[rd_ptr_q[AW-1:0]] ^ DA_XOR;
          end else begin
            cnt_q <= (cnt_q == per_q) ? '0 : cnt_q + DIV_ONE;
            if (cnt_q == half) daclk_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_stream_tx.sv
// Self-checking bench for dac_stream_tx: scoreboard of pushed samples checked at each DACLK rise,
// plus per-scenario timing, backpressure, underrun and reset checks.
module tb_dac_stream_tx;

  localparam int DW = 8;
  localparam int LW = 5;
`ifdef DAC_SIGNED_IN_EN
  localparam logic [7:0] DA_RST = 8'h80;
`else
  localparam logic [7:0] DA_RST = 8'h00;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_enable = 1'b0;
  logic [7:0]    i_div = 8'd1;
  logic [DW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] o_da_port;
  logic          o_daclk;
  logic [LW-1:0] o_level;
  logic          o_underrun;
  logic          i_clr_underrun = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_e;
  logic       daclk_prev = 1'b0;

  dac_stream_tx #(
    .DATA_W(8), .FIFO_DEPTH(16), .DIV_W(8), .PRIME_LEVEL(8)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_div(i_div),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready), .o_da_port(o_da_port),
    .o_daclk(o_daclk), .o_level(o_level), .o_underrun(o_underrun),
    .i_clr_underrun(i_clr_underrun)
  );

  always #20 i_clk = ~i_clk;

  function automatic logic [7:0] dac_map(input logic [7:0] d);
`ifdef DAC_SIGNED_IN_EN
    return d ^ 8'h80;
`else
    return d;
`endif
  endfunction

  // Scoreboard: every DACLK rise presents the oldest outstanding sample; rises with nothing
  // outstanding are underrun periods and carry no new data.
  initial forever begin
    @(negedge i_clk);
    if (i_rst_n && o_daclk && !daclk_prev && exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      checks++;
      if (o_da_port !== sb_e) begin
        failures++;
        $display("FAIL sb_data got=%h exp=%h t=%0t", o_da_port, sb_e, $time);
      end
    end
    daclk_prev = o_daclk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic do_reset();
    i_enable = 1'b0;
    i_valid = 1'b0;
    i_clr_underrun = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge i_clk);
    i_data = d;
    i_valid = 1'b1;
    while (!o_ready && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout data=%h ready=%b", d, o_ready);
    end else begin
      exp_q.push_back(dac_map(d));
    end
    @(posedge i_clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_change(output int n);
    logic [7:0] prev;
    prev = o_da_port;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (o_da_port === prev && n < 100);
    if (o_da_port === prev) begin
      checks++;
      failures++;
      $display("FAIL change_timeout got=%h waited=%0d", o_da_port, n);
    end
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", o_ready); end
    checks++; if (o_level !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", o_level); end
    checks++; if (o_da_port !== DA_RST) begin failures++; $display("FAIL rst_da got=%h exp=%h", o_da_port, DA_RST); end
    checks++; if (o_daclk !== 1'b0) begin failures++; $display("FAIL rst_daclk got=%b exp=0", o_daclk); end
    checks++; if (o_underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun got=%b exp=0", o_underrun); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_prime_pace();
    logic [7:0] da_s [0:36];
    logic       ck_s [0:36];
    logic [4:0] lv_s [0:36];
    int chg [8];
    int nchg;
    int lim;
    do_reset();
    i_div = 8'd3;
    for (int k = 0; k < 8; k++) push(8'h10 + 8'(k));
    @(negedge i_clk);
    checks++; if (o_level !== 5'd8) begin failures++; $display("FAIL prime_level got=%0d exp=8", o_level); end
    checks++; if (o_da_port !== DA_RST) begin failures++; $display("FAIL prime_idle_da got=%h exp=%h", o_da_port, DA_RST); end
    da_s[0] = o_da_port; ck_s[0] = o_daclk; lv_s[0] = o_level;
    i_enable = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      @(negedge i_clk);
      da_s[i] = o_da_port; ck_s[i] = o_daclk; lv_s[i] = o_level;
    end
    nchg = 0;
    for (int k = 0; k < 8; k++) chg[k] = 0;
    for (int i = 1; i <= 36; i++) begin
      if (da_s[i] !== da_s[i-1]) begin
        if (nchg < 8) chg[nchg] = i;
        nchg++;
      end
    end
    checks++; if (nchg != 8) begin failures++; $display("FAIL pace_nchanges got=%0d exp=8", nchg); end
    checks++; if (chg[0] != 3) begin failures++; $display("FAIL pace_latency got=%0d exp=3", chg[0]); end
    lim = (nchg < 8) ? nchg : 8;
    for (int k = 0; k < lim; k++) begin
      checks++;
      if (da_s[chg[k]] !== dac_map(8'h10 + 8'(k))) begin
        failures++; $display("FAIL pace_data k=%0d got=%h exp=%h", k, da_s[chg[k]], dac_map(8'h10 + 8'(k)));
      end
      checks++;
      if (lv_s[chg[k]] !== 5'(7 - k)) begin
        failures++; $display("FAIL pace_level k=%0d got=%0d exp=%0d", k, lv_s[chg[k]], 7 - k);
      end
      checks++;
      if (ck_s[chg[k]+1] !== 1'b0 || ck_s[chg[k]+2] !== 1'b1) begin
        failures++; $display("FAIL pace_daclk k=%0d got=%b%b exp=01", k, ck_s[chg[k]+1], ck_s[chg[k]+2]);
      end
      if (k > 0) begin
        checks++;
        if (chg[k] - chg[k-1] != 4) begin
          failures++; $display("FAIL pace_period k=%0d got=%0d exp=4", k, chg[k] - chg[k-1]);
        end
      end
    end
  endtask

  task automatic test_full_backpressure();
    do_reset();
    i_div = 8'd1;
    for (int k = 0; k < 16; k++) push(8'h40 + 8'(k));
    @(negedge i_clk);
    checks++; if (o_level !== 5'd16) begin failures++; $display("FAIL full_level got=%0d exp=16", o_level); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", o_ready); end
    fork
      push(8'h50);
      begin
        repeat (4) @(negedge i_clk);
        checks++; if (o_level !== 5'd16) begin failures++; $display("FAIL full_hold_level got=%0d exp=16", o_level); end
        i_enable = 1'b1;
      end
    join
    repeat (60) @(negedge i_clk);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_drain_pending got=%0d exp=0", exp_q.size()); end
    checks++; if (o_level !== 5'd0) begin failures++; $display("FAIL full_drain_level got=%0d exp=0", o_level); end
    checks++; if (o_da_port !== dac_map(8'h50)) begin failures++; $display("FAIL full_last got=%h exp=%h", o_da_port, dac_map(8'h50)); end
  endtask

  task automatic test_underrun();
    int n;
    do_reset();
    i_div = 8'd1;
    for (int k = 0; k < 8; k++) push(8'h60 + 8'(k));
    i_enable = 1'b1;
    repeat (40) @(negedge i_clk);
    checks++; if (o_underrun !== 1'b1) begin failures++; $display("FAIL ur_set got=%b exp=1", o_underrun); end
    checks++; if (o_da_port !== dac_map(8'h67)) begin failures++; $display("FAIL ur_hold got=%h exp=%h", o_da_port, dac_map(8'h67)); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ur_pending got=%0d exp=0", exp_q.size()); end
    // With P=2, DACLK high means the next edge is a tick: clear collides with set there.
    n = 0;
    while (o_daclk !== 1'b1 && n < 20) begin @(negedge i_clk); n++; end
    i_clr_underrun = 1'b1;
    @(negedge i_clk);
    checks++; if (o_underrun !== 1'b1) begin failures++; $display("FAIL ur_set_priority got=%b exp=1", o_underrun); end
    @(negedge i_clk);
    checks++; if (o_underrun !== 1'b0) begin failures++; $display("FAIL ur_clr_offtick got=%b exp=0", o_underrun); end
    i_clr_underrun = 1'b0;
    repeat (2) @(negedge i_clk);
    i_enable = 1'b0;
    for (int k = 0; k < 8; k++) push(8'h70 + 8'(k));
    @(negedge i_clk);
    checks++; if (o_underrun !== 1'b1) begin failures++; $display("FAIL ur_sticky got=%b exp=1", o_underrun); end
    i_clr_underrun = 1'b1;
    @(negedge i_clk);
    i_clr_underrun = 1'b0;
    checks++; if (o_underrun !== 1'b0) begin failures++; $display("FAIL ur_clear got=%b exp=0", o_underrun); end
    repeat (5) @(negedge i_clk);
    checks++; if (o_underrun !== 1'b0) begin failures++; $display("FAIL ur_stays_clear got=%b exp=0", o_underrun); end
    checks++; if (o_level !== 5'd8) begin failures++; $display("FAIL ur_refill_level got=%0d exp=8", o_level); end
    i_enable = 1'b1;
    repeat (40) @(negedge i_clk);
    checks++; if (o_underrun !== 1'b1) begin failures++; $display("FAIL ur_reset_pre got=%b exp=1", o_underrun); end
    n = 0;
    while (o_daclk !== 1'b1 && n < 20) begin @(negedge i_clk); n++; end
    #5 i_rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++; if (o_da_port !== DA_RST) begin failures++; $display("FAIL midrst_da got=%h exp=%h", o_da_port, DA_RST); end
    checks++; if (o_daclk !== 1'b0) begin failures++; $display("FAIL midrst_daclk got=%b exp=0", o_daclk); end
    checks++; if (o_underrun !== 1'b0) begin failures++; $display("FAIL midrst_underrun got=%b exp=0", o_underrun); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", o_ready); end
    @(negedge i_clk);
    i_enable = 1'b0;
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_divider();
    int n;
    do_reset();
    i_div = 8'd0;
    for (int k = 0; k < 8; k++) push(8'h20 + 8'(k));
    i_enable = 1'b1;
    wait_change(n);
    for (int j = 0; j < 2; j++) begin
      wait_change(n);
      checks++; if (n != 2) begin failures++; $display("FAIL div0_period j=%0d got=%0d exp=2", j, n); end
    end
    do_reset();
    i_div = 8'd3;
    for (int k = 0; k < 8; k++) push(8'h30 + 8'(k));
    i_enable = 1'b1;
    wait_change(n);
    i_div = 8'd7;
    wait_change(n);
    checks++; if (n != 4) begin failures++; $display("FAIL div_change_cur got=%0d exp=4", n); end
    wait_change(n);
    checks++; if (n != 8) begin failures++; $display("FAIL div_change_next got=%0d exp=8", n); end
    wait_change(n);
    checks++; if (n != 8) begin failures++; $display("FAIL div_change_next2 got=%0d exp=8", n); end
  endtask

  task automatic test_data_map();
    logic [7:0] exp_tab [3];
    int n;
`ifdef DAC_SIGNED_IN_EN
    exp_tab[0] = 8'hFF; exp_tab[1] = 8'h00; exp_tab[2] = 8'h80;
`else
    exp_tab[0] = 8'h7F; exp_tab[1] = 8'h80; exp_tab[2] = 8'h00;
`endif
    do_reset();
    i_div = 8'd1;
    push(8'h7F); push(8'h80); push(8'h00);
    for (int k = 1; k <= 5; k++) push(8'(k));
    i_enable = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_change(n);
      checks++;
      if (o_da_port !== exp_tab[j]) begin
        failures++; $display("FAIL map j=%0d got=%h exp=%h", j, o_da_port, exp_tab[j]);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    test_reset();
    test_prime_pace();
    test_full_backpressure();
    test_underrun();
    test_divider();
    test_data_map();
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
